// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: radix-2 shift-add multiply, restoring divide.
// Divide-by-zero and signed overflow complete on a single-cycle fast path.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            sel_i,
  input  logic [1:0]      op_mul_i,
  input  logic [1:0]      op_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  // state | meaning
  // IDLE  | waiting for start_i
  // CALC  | one multiply/divide iteration per clock
  // DONE  | result valid, done_o pulse
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic            sel;
  logic [1:0]      op;
  logic            neg;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] hi, lo, opd, result;

  logic            a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            accept, last;

  logic [XLEN:0]     sum, shl, diff;
  logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo, hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  // operand conditioning at accept time
  always_comb begin
    a_sgn    = sel_i ? ~op_div_i[0] : (op_mul_i != 2'b11);
    b_sgn    = sel_i ? ~op_div_i[0] : ~op_mul_i[1];
    a_neg    = a_sgn & a_i[XLEN-1];
    b_neg    = b_sgn & b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    neg_in   = (sel_i & op_div_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = (b_i == '0);
    ovf      = ~op_div_i[0] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
    fast     = sel_i & (div_zero | ovf);
    if (div_zero) fast_res = op_div_i[1] ? a_i : '1;
    else          fast_res = op_div_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // one iteration of either algorithm; hi/lo hold {product} or {remainder, quotient}
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    mul_hi = sum[XLEN:1];
    mul_lo = {sum[0], lo[XLEN-1:1]};
    shl    = {hi, lo[XLEN-1]};
    diff   = shl - {1'b0, opd};
    if (!diff[XLEN]) begin
      div_hi = diff[XLEN-1:0];
      div_lo = {lo[XLEN-2:0], 1'b1};
    end else begin
      div_hi = shl[XLEN-1:0];
      div_lo = {lo[XLEN-2:0], 1'b0};
    end
    hi_nxt = sel ? div_hi : mul_hi;
    lo_nxt = sel ? div_lo : mul_lo;
  end

  always_comb begin
    prod   = {hi_nxt, lo_nxt};
    prod_s = neg ? -prod : prod;
    quo_s  = neg ? -lo_nxt : lo_nxt;
    rem_s  = neg ? -hi_nxt : hi_nxt;
    if (sel)             final_res = op[1] ? rem_s : quo_s;
    else if (op == 2'b00) final_res = prod_s[XLEN-1:0];
    else                 final_res = prod_s[2*XLEN-1:XLEN];
  end

  assign accept = (state == IDLE) & start_i & ~kill_i;
  assign last   = (count == CW'(XLEN-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sel    <= 1'b0;
      op     <= 2'b00;
      neg    <= 1'b0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      opd    <= '0;
      result <= '0;
    end else if (accept) begin
      sel   <= sel_i;
      op    <= sel_i ? op_div_i : op_mul_i;
      neg   <= neg_in;
      count <= '0;
      hi    <= '0;
      lo    <= sel_i ? a_mag : b_mag;
      opd   <= sel_i ? b_mag : a_mag;
      if (fast) result <= fast_res;
    end else if (state == CALC && !kill_i) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      if (last) begin
        count  <= '0;
        result <= final_res;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign busy_o   = (state == CALC);
  assign done_o   = (state == DONE);
  assign result_o = result;

endmodule
